// File: rtl/pc_run_controller.sv
// Program-run sequencer: owns the program counter, sequences IDLE/LOAD/RUN/DONE
// and reports completion (halt or watchdog) to the host through a done/ack handshake.
module pc_run_controller #(
  parameter int D          = 12,
  parameter int CW         = 16,
  parameter int MAX_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [D-1:0]  start_address,
  input  logic          abort,
  input  logic          stall,
  input  logic          branch,
  input  logic          taken,
  input  logic [D-1:0]  target,
  input  logic          halt,
  output logic [D-1:0]  prog_ctr,
  output logic          fetch_en,
  output logic          busy,
  output logic          done,
  input  logic          done_ack,
  output logic          timeout,
  output logic [CW-1:0] cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam bit          WD_EN   = (MAX_CYCLES != 0);
  localparam logic [CW-1:0] WD_LAST = WD_EN ? CW'(MAX_CYCLES - 1) : {CW{1'b0}};
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t        state_q, state_d;
  logic [D-1:0]  prog_ctr_q, prog_ctr_d;
  logic [CW-1:0] cycle_count_q, cycle_count_d;
  logic          timeout_q, timeout_d;
  logic          req_ready_q, req_ready_d;
  logic          fetch_en_q, fetch_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          wd_hit_s;

  // Saturating RUN-cycle counter increment.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
    if (cnt == CNT_MAX) begin
      sat_inc = cnt;
    end else begin
      sat_inc = cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  endfunction

  // Non-stalled next PC; relative branch offset is two's complement, wrapping mod 2**D.
  function automatic logic [D-1:0] next_pc(
    input logic [D-1:0] pc,
    input logic         br,
    input logic         tk,
    input logic [D-1:0] off
  );
    if (br && tk) begin
      next_pc = pc + off;
    end else begin
      next_pc = pc + {{(D-1){1'b0}}, 1'b1};
    end
  endfunction

  assign wd_hit_s = WD_EN && (cycle_count_q == WD_LAST);

  // Next-state and datapath update.
  always_comb begin
    state_d       = state_q;
    prog_ctr_d    = prog_ctr_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          prog_ctr_d    = start_address;
          cycle_count_d = {CW{1'b0}};
          timeout_d     = 1'b0;
          state_d       = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cycle_count_d = sat_inc(cycle_count_q);
        if (abort) begin
          state_d = S_IDLE;
        end else if (halt) begin
          state_d = S_DONE;
        end else if (wd_hit_s) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else if (stall) begin
          prog_ctr_d = prog_ctr_q;
        end else begin
          prog_ctr_d = next_pc(prog_ctr_q, branch, taken, target);
        end
      end
      S_DONE: begin
        if (done_ack) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags are decoded from the next state so they leave the chip from flops.
  always_comb begin
    req_ready_d = 1'b0;
    fetch_en_d  = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      S_IDLE:  req_ready_d = 1'b1;
      S_LOAD:  busy_d      = 1'b1;
      S_RUN: begin
        busy_d     = 1'b1;
        fetch_en_d = 1'b1;
      end
      S_DONE:  done_d      = 1'b1;
      default: req_ready_d = 1'b1;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      prog_ctr_q    <= {D{1'b0}};
      cycle_count_q <= {CW{1'b0}};
      timeout_q     <= 1'b0;
      req_ready_q   <= 1'b1;
      fetch_en_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      prog_ctr_q    <= prog_ctr_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
      req_ready_q   <= req_ready_d;
      fetch_en_q    <= fetch_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign fetch_en    = fetch_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign prog_ctr    = prog_ctr_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_pc_run_controller.sv
// Bench for pc_run_controller: directed scenarios plus random traffic, two instances
// (default watchdog and an 8-cycle watchdog) checked against a run-level model.
module tb_pc_run_controller;

  logic        clk = 1'b0;
  logic        reset_n, req_valid, abort, stall, branch, taken, halt, done_ack;
  logic [11:0] start_address, target;

  logic        a_ready, a_fetch, a_busy, a_done, a_to;
  logic [11:0] a_pc;
  logic [15:0] a_cnt;
  logic        b_ready, b_fetch, b_busy, b_done, b_to;
  logic [11:0] b_pc;
  logic [15:0] b_cnt;

  always #5 clk = ~clk;

  pc_run_controller dut_a (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(a_ready),
    .start_address(start_address), .abort(abort), .stall(stall), .branch(branch),
    .taken(taken), .target(target), .halt(halt), .prog_ctr(a_pc), .fetch_en(a_fetch),
    .busy(a_busy), .done(a_done), .done_ack(done_ack), .timeout(a_to),
    .cycle_count(a_cnt)
  );

  pc_run_controller #(.MAX_CYCLES(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(b_ready),
    .start_address(start_address), .abort(abort), .stall(stall), .branch(branch),
    .taken(taken), .target(target), .halt(halt), .prog_ctr(b_pc), .fetch_en(b_fetch),
    .busy(b_busy), .done(b_done), .done_ack(done_ack), .timeout(b_to),
    .cycle_count(b_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: phase of the run, PC, cycle count and timeout flag per instance.
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_RUN = 2, PH_DONE = 3;
  int          m_ph  [2];
  logic [11:0] m_pc  [2];
  logic [15:0] m_cnt [2];
  logic        m_to  [2];
  int          m_max [2] = '{4096, 8};

  task automatic model_step(input int k);
    logic [15:0] old;
    old = m_cnt[k];
    if (!reset_n) begin
      m_ph[k] = PH_IDLE; m_pc[k] = 12'h000; m_cnt[k] = 16'h0000; m_to[k] = 1'b0;
    end else if (m_ph[k] == PH_IDLE) begin
      if (req_valid) begin
        m_ph[k] = PH_LOAD; m_pc[k] = start_address; m_cnt[k] = 16'h0000; m_to[k] = 1'b0;
      end
    end else if (m_ph[k] == PH_LOAD) begin
      m_ph[k] = abort ? PH_IDLE : PH_RUN;
    end else if (m_ph[k] == PH_RUN) begin
      if (old != 16'hFFFF) m_cnt[k] = old + 16'd1;
      if (abort) m_ph[k] = PH_IDLE;
      else if (halt) m_ph[k] = PH_DONE;
      else if (m_max[k] != 0 && 32'(old) == m_max[k] - 1) begin
        m_ph[k] = PH_DONE; m_to[k] = 1'b1;
      end else if (!stall) begin
        m_pc[k] = (branch && taken) ? 12'((int'(m_pc[k]) + int'(target)) % 4096)
                                    : 12'((int'(m_pc[k]) + 1) % 4096);
      end
    end else begin
      if (done_ack) m_ph[k] = PH_IDLE;
    end
  endtask

  task automatic compare_inst(input int k, input logic rdy, input logic fe, input logic bz,
                              input logic dn, input logic to, input logic [11:0] pc,
                              input logic [15:0] cnt);
    string p;
    p = (k == 0) ? "a" : "b";
    check({p, ".req_ready"},   32'(rdy), 32'(m_ph[k] == PH_IDLE));
    check({p, ".fetch_en"},    32'(fe),  32'(m_ph[k] == PH_RUN));
    check({p, ".busy"},        32'(bz),  32'(m_ph[k] == PH_LOAD || m_ph[k] == PH_RUN));
    check({p, ".done"},        32'(dn),  32'(m_ph[k] == PH_DONE));
    check({p, ".timeout"},     32'(to),  32'(m_to[k]));
    check({p, ".prog_ctr"},    32'(pc),  32'(m_pc[k]));
    check({p, ".cycle_count"}, 32'(cnt), 32'(m_cnt[k]));
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_inst(0, a_ready, a_fetch, a_busy, a_done, a_to, a_pc, a_cnt);
    compare_inst(1, b_ready, b_fetch, b_busy, b_done, b_to, b_pc, b_cnt);
  endtask

  task automatic quiet();
    req_valid = 1'b0; abort = 1'b0; stall = 1'b0; branch = 1'b0; taken = 1'b0;
    halt = 1'b0; done_ack = 1'b0; start_address = 12'h000; target = 12'h000;
  endtask

  initial begin
    logic [15:0] c0;
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = PH_IDLE; m_pc[k] = 12'h000; m_cnt[k] = 16'h0000; m_to[k] = 1'b0;
    end
    quiet();
    reset_n = 1'b0;
    step(); step();
    check("rst.req_ready", 32'(a_ready), 32'd1);
    check("rst.pc", 32'(a_pc), 32'h000);
    check("rst.busy", 32'(a_busy), 32'd0);
    reset_n = 1'b1;

    // Accept, LOAD bubble, sequential RUN
    req_valid = 1'b1; start_address = 12'h010;
    step();
    check("load.req_ready", 32'(a_ready), 32'd0);
    check("load.pc", 32'(a_pc), 32'h010);
    check("load.fetch_en", 32'(a_fetch), 32'd0);
    quiet();
    step(); check("run.pc0", 32'(a_pc), 32'h010); check("run.fetch_en", 32'(a_fetch), 32'd1);
    step(); check("run.pc1", 32'(a_pc), 32'h011);
    step(); check("run.pc2", 32'(a_pc), 32'h012);
    step(); step(); check("run.pc4", 32'(a_pc), 32'h014);

    // Backward branch, then not-taken branch
    branch = 1'b1; taken = 1'b1; target = 12'hFFE;
    step(); check("br.taken", 32'(a_pc), 32'h012);
    taken = 1'b0;
    step(); check("br.not_taken", 32'(a_pc), 32'h013);
    quiet();
    repeat (13) step();
    check("seq.pc20", 32'(a_pc), 32'h020);

    // Stall holds PC while counting
    c0 = a_cnt;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check("stall.hold", 32'(a_pc), 32'h020);
    end
    check("stall.count", 32'(a_cnt), 32'(c0 + 16'd3));
    stall = 1'b0;
    step(); check("stall.release", 32'(a_pc), 32'h021);
    repeat (4) step();
    check("seq.pc25", 32'(a_pc), 32'h025);

    // Halt wins over stall; done held until ack
    halt = 1'b1; stall = 1'b1;
    step();
    check("halt.done", 32'(a_done), 32'd1);
    check("halt.pc", 32'(a_pc), 32'h025);
    check("halt.timeout", 32'(a_to), 32'd0);
    quiet();
    for (int i = 0; i < 5; i++) begin
      step(); check("done.hold", 32'(a_done), 32'd1);
    end
    done_ack = 1'b1;
    step();
    check("ack.req_ready", 32'(a_ready), 32'd1);
    check("ack.done", 32'(a_done), 32'd0);
    quiet();

    // Watchdog on the 8-cycle instance, with PC wrap
    req_valid = 1'b1; start_address = 12'hFFE;
    step();
    quiet();
    for (int i = 0; i < 8; i++) begin
      logic [11:0] e;
      e = 12'hFFE + 12'(i);
      step(); check("wd.pc", 32'(b_pc), 32'(e));
    end
    step();
    check("wd.done", 32'(b_done), 32'd1);
    check("wd.timeout", 32'(b_to), 32'd1);
    check("wd.count", 32'(b_cnt), 32'd8);
    check("wd.pc_held", 32'(b_pc), 32'h005);
    done_ack = 1'b1;
    step();
    quiet();
    check("wd.ack", 32'(b_ready), 32'd1);

    // Reset mid-run
    reset_n = 1'b0;
    step();
    check("midrst.pc", 32'(a_pc), 32'h000);
    check("midrst.cnt", 32'(a_cnt), 32'd0);
    check("midrst.ready", 32'(a_ready), 32'd1);
    reset_n = 1'b1;

    // Abort in LOAD and in RUN
    req_valid = 1'b1; start_address = 12'h100;
    step();
    quiet(); abort = 1'b1;
    step();
    check("abort_load.ready", 32'(a_ready), 32'd1);
    check("abort_load.done", 32'(a_done), 32'd0);
    quiet(); req_valid = 1'b1; start_address = 12'h200;
    step();
    quiet();
    step(); step();
    abort = 1'b1;
    step();
    check("abort_run.ready", 32'(a_ready), 32'd1);
    check("abort_run.busy", 32'(a_busy), 32'd0);
    quiet();
    step(); check("abort_run.done", 32'(a_done), 32'd0);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      reset_n       = ($urandom_range(0, 299) != 0);
      req_valid     = ($urandom_range(0, 99) < 50);
      abort         = ($urandom_range(0, 99) < 3);
      stall         = ($urandom_range(0, 99) < 20);
      branch        = ($urandom_range(0, 99) < 25);
      taken         = ($urandom_range(0, 1) == 1);
      halt          = ($urandom_range(0, 99) < 3);
      done_ack      = ($urandom_range(0, 99) < 30);
      start_address = 12'($urandom);
      target        = 12'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
